// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures timestamped register writes from the MIPS
// write-back stage into a FWFT FIFO and keeps cycle/stall/drop counters for CPI work.
module wb_trace_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Enable,
    input  logic                       RegWrite_WB,
    input  logic [4:0]                 rDestSelected_WB,
    input  logic [31:0]                regWriteData,
    input  logic [31:0]                PC_In,
    input  logic                       Stall_In,
    input  logic                       Rd_Ready,
    output logic                       Rd_Valid,
    output logic [4:0]                 Rd_Dest,
    output logic [31:0]                Rd_Data,
    output logic [31:0]                Rd_PC,
    output logic [CNT_W-1:0]           Rd_Stamp,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Overflow,
    output logic [CNT_W-1:0]           Cycle_Count,
    output logic [CNT_W-1:0]           Stall_Count,
    output logic [CNT_W-1:0]           Drop_Count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [CNT_W-1:0] stamp;
        logic [4:0]       dest;
        logic [31:0]      data;
        logic [31:0]      pc;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    entry_t         head;
    entry_t         new_entry;

    logic push;
    logic pop;
    logic full;
    logic store;
    logic drop;

    always_comb begin
        push  = Enable & RegWrite_WB & (rDestSelected_WB != 5'd0);
        full  = (Count == FULL_CNT);
        pop   = Rd_Valid & Rd_Ready;
        // A pop frees the slot in the same edge, so a full FIFO still accepts.
        store = push & (~full | pop);
        drop  = push & full & ~pop;
    end

    always_comb begin
        new_entry.stamp = Cycle_Count;
        new_entry.dest  = rDestSelected_WB;
        new_entry.data  = regWriteData;
        new_entry.pc    = PC_In;
    end

    always_ff @(posedge Clock) begin
        if (store) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({store, pop})
                2'b10:   Count <= Count + CW'(1);
                2'b01:   Count <= Count - CW'(1);
                default: Count <= Count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Overflow    <= 1'b0;
            Cycle_Count <= '0;
            Stall_Count <= '0;
            Drop_Count  <= '0;
        end else begin
            if (Enable) begin
                Cycle_Count <= Cycle_Count + CNT_W'(1);
            end
            if (Enable & Stall_In) begin
                Stall_Count <= Stall_Count + CNT_W'(1);
            end
            if (drop) begin
                Overflow   <= 1'b1;
                Drop_Count <= Drop_Count + CNT_W'(1);
            end
        end
    end

    // First-word-fall-through: head is presented straight from storage, zeroed when empty.
    always_comb begin
        Rd_Valid = (Count != '0);
        head     = mem[rd_ptr];
        if (Rd_Valid) begin
            Rd_Dest  = head.dest;
            Rd_Data  = head.data;
            Rd_PC    = head.pc;
            Rd_Stamp = head.stamp;
        end else begin
            Rd_Dest  = '0;
            Rd_Data  = '0;
            Rd_PC    = '0;
            Rd_Stamp = '0;
        end
    end

endmodule
